// File: rtl/multi_chan_debounce.sv
// Multi-channel debounce filter: synchroniser, stability counter, rise/fall strobes.
// Define PERIOD_MEAS_EN to build the rise-to-rise period measurement per channel.
module multi_chan_debounce #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PER_W       = 20,
    parameter int unsigned FAST_SIM    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         din,
    input  logic [CNT_W-1:0]          stable_thresh,
    output logic [NUM_CH-1:0]         filt,
    output logic [NUM_CH-1:0]         rise,
    output logic [NUM_CH-1:0]         fall,
    output logic [NUM_CH*PER_W-1:0]   period,
    output logic [NUM_CH-1:0]         period_vld
);

    logic [CNT_W-1:0] w_thr_eff;

    // Simulation shortcut caps the threshold; only meaningful if CNT_W can exceed 511.
    generate
        if (FAST_SIM != 0 && CNT_W > 9) begin : g_thr_fast
            assign w_thr_eff = (stable_thresh > CNT_W'(511)) ? CNT_W'(511) : stable_thresh;
        end else begin : g_thr_full
            assign w_thr_eff = stable_thresh;
        end
    endgenerate

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_filt;
        logic                   r_filt_d;
        logic                   w_s;
        logic                   w_rise;

        assign w_s    = r_sync[SYNC_STAGES-1];
        assign w_rise = r_filt & ~r_filt_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync   <= '0;
                r_cnt    <= '0;
                r_filt   <= 1'b0;
                r_filt_d <= 1'b0;
            end else begin
                r_sync   <= {r_sync[SYNC_STAGES-2:0], din[g]};
                r_filt_d <= r_filt;
                // >= so a threshold lowered below the running count fires next cycle
                if (w_s == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt >= w_thr_eff) begin
                    r_filt <= w_s;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign filt[g] = r_filt;
        assign rise[g] = w_rise;
        assign fall[g] = ~r_filt & r_filt_d;

`ifdef PERIOD_MEAS_EN
        logic [PER_W-1:0] r_pcnt;
        logic [PER_W-1:0] r_period;
        logic             r_armed;
        logic             r_vld;

        // First rise after reset only arms; all-ones period means stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pcnt   <= '0;
                r_period <= '0;
                r_armed  <= 1'b0;
                r_vld    <= 1'b0;
            end else begin
                r_vld <= w_rise & r_armed;
                if (w_rise) begin
                    r_pcnt  <= PER_W'(1);
                    r_armed <= 1'b1;
                    if (r_armed) begin
                        r_period <= r_pcnt;
                    end
                end else if (r_pcnt != '1) begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end
        end

        assign period[g*PER_W +: PER_W] = r_period;
        assign period_vld[g]            = r_vld;
`else
        assign period[g*PER_W +: PER_W] = '0;
        assign period_vld[g]            = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_chan_debounce.sv
// Directed bench for multi_chan_debounce (NUM_CH=4, THR=5, FAST_SIM=0, PER_W=10).
module tb_multi_chan_debounce;

    localparam int NUM_CH = 4;
    localparam int PER_W  = 10;
`ifdef PERIOD_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       din;
    logic [15:0]             stable_thresh;
    logic [NUM_CH-1:0]       filt;
    logic [NUM_CH-1:0]       rise;
    logic [NUM_CH-1:0]       fall;
    logic [NUM_CH*PER_W-1:0] period;
    logic [NUM_CH-1:0]       period_vld;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_chan_debounce #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(2), .CNT_W(16), .PER_W(PER_W), .FAST_SIM(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .stable_thresh(stable_thresh),
        .filt(filt), .rise(rise), .fall(fall), .period(period), .period_vld(period_vld)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PER_W-1:0] per(input int ch);
        return period[ch*PER_W +: PER_W];
    endfunction

    initial begin
        rst_n         = 1'b0;
        din           = '0;
        stable_thresh = 16'd5;

        // Reset held: toggling inputs must not disturb any output
        for (int i = 0; i < 8; i++) begin
            din = 4'(i * 5);
            tick();
            check("rst_filt", filt, 0);
            check("rst_rise", rise, 0);
            check("rst_fall", fall, 0);
            check("rst_period", period, 0);
            check("rst_vld", period_vld, 0);
        end
        din = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Clean step on ch0: filt rises on the 8th edge counting the sampling edge
        din[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("step_hold", filt, 4'b0000);
        end
        tick();
        check("step_filt", filt, 4'b0001);
        check("step_rise", rise, 4'b0001);
        tick();
        check("step_rise_end", rise, 4'b0000);

        // 5-cycle glitch on ch1 rejected, then a sustained high accepted
        din[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("glitch_hi", filt, 4'b0001);
        end
        din[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch_lo", filt, 4'b0001);
        end
        din[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("glitch_wait", filt, 4'b0001);
        end
        tick();
        check("glitch_filt", filt, 4'b0011);
        check("glitch_rise", rise, 4'b0010);

        // Threshold drop with ch0 count at 4: fall accepted on the next edge
        din[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("thr_hold", filt, 4'b0011);
        end
        stable_thresh = 16'd2;
        tick();
        check("thr_filt", filt, 4'b0010);
        check("thr_fall", fall, 4'b0001);
        stable_thresh = 16'd5;
        tick();
        check("thr_fall_end", fall, 4'b0000);

        // 100-clock square wave on ch2: rises at c=7,107,..; period 100 one cycle later
        for (int c = 0; c < 340; c++) begin
            din[2] = ((c % 100) < 50);
            tick();
            check("sq_rise", rise[2], ((c % 100) == 7));
            check("sq_fall", fall[2], ((c % 100) == 57));
            check("sq_vld", period_vld[2], MEAS && (c == 108 || c == 208 || c == 308));
            if (c == 108 || c == 208 || c == 308)
                check("sq_period", per(2), MEAS ? 100 : 0);
        end
        din[2] = 1'b0;

        // Stall on ch3: interval beyond 2^PER_W-1 reports all ones
        din[3] = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tick();
        check("stall_rise1", rise[3], 1);
        tick();
        check("stall_arm_novld", period_vld[3], 0);
        for (int i = 0; i < 20; i++) tick();
        din[3] = 1'b0;
        for (int i = 0; i < 1100; i++) tick();
        din[3] = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tick();
        check("stall_rise2", rise[3], 1);
        tick();
        check("stall_vld", period_vld[3], MEAS);
        check("stall_period", per(3), MEAS ? 10'h3FF : 10'h000);

        // Reset mid-interval discards the armed state
        for (int i = 0; i < 20; i++) tick();
        din[3] = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        tick(); tick();
        check("mrst_filt", filt, 0);
        check("mrst_period", period, 0);
        check("mrst_vld", period_vld, 0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        for (int c = 0; c < 100; c++) begin
            din[3] = (c < 40) || (c >= 80);
            tick();
            check("mrst_rise", rise[3], (c == 7 || c == 87));
            check("mrst_vld3", period_vld[3], MEAS && (c == 88));
            if (c == 88)
                check("mrst_period3", per(3), MEAS ? 80 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
